// File: rtl/lcd_ctrl_pkg.sv
// Shared opcode and FSM state encodings for the LCD image controller.
package lcd_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_WRITE    = 4'd0,
    OP_UP       = 4'd1,
    OP_DOWN     = 4'd2,
    OP_LEFT     = 4'd3,
    OP_RIGHT    = 4'd4,
    OP_MAX      = 4'd5,
    OP_MIN      = 4'd6,
    OP_AVG      = 4'd7,
    OP_ROT_CCW  = 4'd8,
    OP_ROT_CW   = 4'd9,
    OP_MIRROR_X = 4'd10,
    OP_MIRROR_Y = 4'd11
  } opcode_e;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Opcodes that rewrite the 2x2 window (as opposed to moving the point).
  function automatic logic is_window_op(input logic [3:0] op);
    return (op >= 4'd5) && (op <= 4'd11);
  endfunction

endpackage

// File: rtl/lcd_window_alu.sv
// Combinational 2x2 window transform: maps a,b,c,d (row-major [a b; c d])
// and an opcode to the four replacement pixels.
module lcd_window_alu
  import lcd_ctrl_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  input  logic [DW-1:0] d,
  input  logic [3:0]    op,
  output logic [DW-1:0] na,
  output logic [DW-1:0] nb,
  output logic [DW-1:0] nc,
  output logic [DW-1:0] nd
);

  logic [DW-1:0] max_ab_s, max_cd_s, max_s;
  logic [DW-1:0] min_ab_s, min_cd_s, min_s;
  logic [DW+1:0] sum_s;

  assign max_ab_s = (a > b) ? a : b;
  assign max_cd_s = (c > d) ? c : d;
  assign max_s    = (max_ab_s > max_cd_s) ? max_ab_s : max_cd_s;
  assign min_ab_s = (a < b) ? a : b;
  assign min_cd_s = (c < d) ? c : d;
  assign min_s    = (min_ab_s < min_cd_s) ? min_ab_s : min_cd_s;
  assign sum_s    = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};

  // Select the replacement window for the requested opcode.
  always_comb begin
    na = a;
    nb = b;
    nc = c;
    nd = d;
    case (op)
      OP_MAX:      begin na = max_s; nb = max_s; nc = max_s; nd = max_s; end
      OP_MIN:      begin na = min_s; nb = min_s; nc = min_s; nd = min_s; end
      OP_AVG:      begin
        na = sum_s[DW+1:2];
        nb = sum_s[DW+1:2];
        nc = sum_s[DW+1:2];
        nd = sum_s[DW+1:2];
      end
      OP_ROT_CCW:  begin na = b; nb = d; nc = a; nd = c; end
      OP_ROT_CW:   begin na = c; nb = a; nc = d; nd = b; end
      OP_MIRROR_X: begin na = c; nb = d; nc = a; nd = b; end
      OP_MIRROR_Y: begin na = b; nb = a; nc = d; nd = c; end
      default:     begin na = a; nb = b; nc = c; nd = d; end
    endcase
  end

endmodule

// File: rtl/lcd_ctrl_param.sv
// LCD image controller: loads an IMG_W x IMG_H image from ROM, applies 2x2
// window commands around an operation point and streams the image out.
module lcd_ctrl_param
  import lcd_ctrl_pkg::*;
#(
  parameter  int IMG_W = 8,
  parameter  int IMG_H = 8,
  parameter  int DW    = 8,
  localparam int AW    = $clog2(IMG_W * IMG_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  input  logic [DW-1:0] IROM_Q,
  output logic          IROM_EN,
  output logic [AW-1:0] IROM_A,
  output logic          IRB_RW,
  output logic [DW-1:0] IRB_D,
  output logic [AW-1:0] IRB_A,
  output logic          busy,
  output logic          done
);

  localparam int N  = IMG_W * IMG_H;
  localparam int CW = AW + 1;
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  state_e        state_r, state_s;
  logic [DW-1:0] img_r [N];
  logic [CW-1:0] cnt_r, load_idx_s;
  logic [XW-1:0] px_r;
  logic [YW-1:0] py_r;
  logic [3:0]    op_r;
  logic          irom_en_r, irb_rw_r, busy_r, done_r;
  logic [AW-1:0] irom_a_r, irb_a_r, next_a_s;
  logic [DW-1:0] irb_d_r;
  logic          accept_s, load_last_s, write_last_s, win_op_s;
  logic [AW-1:0] idx_a_s, idx_b_s, idx_c_s, idx_d_s;
  logic [DW-1:0] na_s, nb_s, nc_s, nd_s;

  // cnt_r counts edges since reset release; edge j captures ROM word j-1.
  assign load_idx_s   = cnt_r - CW'(1);
  assign load_last_s  = (cnt_r == CW'(N));
  assign write_last_s = (irb_a_r == AW'(N - 1));
  assign next_a_s     = irb_a_r + AW'(1);
  assign accept_s     = cmd_valid & ~busy_r & ((state_r == ST_IDLE) | (state_r == ST_DONE));
  assign win_op_s     = is_window_op(op_r);

  assign idx_d_s = AW'(py_r) * AW'(IMG_W) + AW'(px_r);
  assign idx_c_s = idx_d_s - AW'(1);
  assign idx_b_s = idx_d_s - AW'(IMG_W);
  assign idx_a_s = idx_b_s - AW'(1);

  lcd_window_alu #(.DW(DW)) u_alu (
    .a  (img_r[idx_a_s]),
    .b  (img_r[idx_b_s]),
    .c  (img_r[idx_c_s]),
    .d  (img_r[idx_d_s]),
    .op (op_r),
    .na (na_s),
    .nb (nb_s),
    .nc (nc_s),
    .nd (nd_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= ST_LOAD;
    else        state_r <= state_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_LOAD: begin
        if (load_last_s) state_s = ST_IDLE;
        else             state_s = ST_LOAD;
      end
      ST_IDLE, ST_DONE: begin
        if (accept_s) state_s = (cmd == OP_WRITE) ? ST_WRITE : ST_EXEC;
        else          state_s = ST_IDLE;
      end
      ST_EXEC:  state_s = ST_IDLE;
      ST_WRITE: begin
        if (write_last_s) state_s = ST_DONE;
        else              state_s = ST_WRITE;
      end
      default:  state_s = ST_LOAD;
    endcase
  end

  // Registered outputs, load counter, command latch and operation point.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r     <= CW'(0);
      irom_en_r <= 1'b1;
      irom_a_r  <= AW'(0);
      irb_rw_r  <= 1'b1;
      irb_a_r   <= AW'(0);
      irb_d_r   <= DW'(0);
      busy_r    <= 1'b1;
      done_r    <= 1'b0;
      op_r      <= 4'd0;
      px_r      <= XW'(IMG_W / 2);
      py_r      <= YW'(IMG_H / 2);
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_LOAD: begin
          cnt_r <= cnt_r + CW'(1);
          if (load_last_s) begin
            irom_en_r <= 1'b1;
            irom_a_r  <= AW'(0);
            busy_r    <= 1'b0;
          end else begin
            irom_en_r <= 1'b0;
            irom_a_r  <= cnt_r[AW-1:0];
          end
        end
        ST_IDLE, ST_DONE: begin
          if (accept_s) begin
            busy_r <= 1'b1;
            op_r   <= cmd;
            if (cmd == OP_WRITE) begin
              irb_rw_r <= 1'b0;
              irb_a_r  <= AW'(0);
              irb_d_r  <= img_r[0];
            end
          end
        end
        ST_EXEC: begin
          busy_r <= 1'b0;
          case (op_r)
            OP_UP:    if (py_r > YW'(1))         py_r <= py_r - YW'(1);
            OP_DOWN:  if (py_r < YW'(IMG_H - 1)) py_r <= py_r + YW'(1);
            OP_LEFT:  if (px_r > XW'(1))         px_r <= px_r - XW'(1);
            OP_RIGHT: if (px_r < XW'(IMG_W - 1)) px_r <= px_r + XW'(1);
            default:  ;
          endcase
        end
        ST_WRITE: begin
          if (write_last_s) begin
            irb_rw_r <= 1'b1;
            irb_a_r  <= AW'(0);
            irb_d_r  <= DW'(0);
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
          end else begin
            irb_a_r <= next_a_s;
            irb_d_r <= img_r[next_a_s];
          end
        end
        default: ;
      endcase
    end
  end

  // Image buffer: ROM capture during load, window rewrite during exec.
  always_ff @(posedge clk) begin
    if ((state_r == ST_LOAD) && (cnt_r != CW'(0))) begin
      img_r[load_idx_s[AW-1:0]] <= IROM_Q;
    end else if ((state_r == ST_EXEC) && win_op_s) begin
      img_r[idx_a_s] <= na_s;
      img_r[idx_b_s] <= nb_s;
      img_r[idx_c_s] <= nc_s;
      img_r[idx_d_s] <= nd_s;
    end
  end

  assign IROM_EN = irom_en_r;
  assign IROM_A  = irom_a_r;
  assign IRB_RW  = irb_rw_r;
  assign IRB_A   = irb_a_r;
  assign IRB_D   = irb_d_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Directed bench for lcd_ctrl_param: an 8x8 instance for the command set and
// a 16x8 instance for mid-write reset abort and the longer load.
module tb_lcd_ctrl_param;

  logic       clk = 1'b0;
  logic       rst8 = 1'b0, rst16 = 1'b0;
  logic [3:0] cmd = 4'd0;
  logic       cmd_valid = 1'b0;
  logic       sel = 1'b0;

  logic [7:0] rom8 [64];
  logic [7:0] rom16 [128];
  logic [7:0] q8, q16, d8, d16;
  logic [5:0] ra8, wa8;
  logic [6:0] ra16, wa16;
  logic       en8, en16, rw8, rw16, busy8, busy16, done8, done16;

  logic       c_busy, c_done, c_en, c_rw;
  logic [6:0] c_rom_a, c_a;
  logic [7:0] c_d;

  logic [7:0] wr_mem [128];
  int         wr_cnt = 0, done_cnt = 0;
  logic       seq_err = 1'b0, done_busy = 1'b0;
  int         n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  assign q8  = rom8[ra8];
  assign q16 = rom16[ra16];

  assign c_busy  = sel ? busy16 : busy8;
  assign c_done  = sel ? done16 : done8;
  assign c_en    = sel ? en16   : en8;
  assign c_rw    = sel ? rw16   : rw8;
  assign c_rom_a = sel ? ra16   : {1'b0, ra8};
  assign c_a     = sel ? wa16   : {1'b0, wa8};
  assign c_d     = sel ? d16    : d8;

  lcd_ctrl_param #(.IMG_W(8), .IMG_H(8), .DW(8)) dut (
    .clk(clk), .reset(rst8), .cmd(cmd), .cmd_valid(cmd_valid), .IROM_Q(q8),
    .IROM_EN(en8), .IROM_A(ra8), .IRB_RW(rw8), .IRB_D(d8), .IRB_A(wa8),
    .busy(busy8), .done(done8)
  );

  lcd_ctrl_param #(.IMG_W(16), .IMG_H(8), .DW(8)) dut16 (
    .clk(clk), .reset(rst16), .cmd(cmd), .cmd_valid(cmd_valid), .IROM_Q(q16),
    .IROM_EN(en16), .IROM_A(ra16), .IRB_RW(rw16), .IRB_D(d16), .IRB_A(wa16),
    .busy(busy16), .done(done16)
  );

  // Write-port monitor, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (c_rw === 1'b0) begin
      if (c_a !== 7'(wr_cnt)) seq_err = 1'b1;
      wr_mem[c_a] = c_d;
      wr_cnt++;
    end
    if (c_done === 1'b1) begin
      done_cnt++;
      done_busy = c_busy;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_load(input int n, input string tag);
    int   cyc;
    logic bad;
    if (sel) rst16 = 1'b0; else rst8 = 1'b0;
    repeat (2) @(negedge clk);
    check_eq({tag, "_rst_busy"}, c_busy, 1);
    check_eq({tag, "_rst_ctl"}, {c_done, c_en, c_rw}, 3'b011);
    check_eq({tag, "_rst_addr"}, {c_rom_a, c_a, c_d}, 0);
    wr_cnt = 0;
    done_cnt = 0;
    if (sel) rst16 = 1'b1; else rst8 = 1'b1;
    cyc = 0;
    bad = 1'b0;
    while (c_busy === 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (c_busy === 1'b1 && (c_en !== 1'b0 || c_rom_a !== 7'(cyc - 1))) bad = 1'b1;
    end
    check_eq({tag, "_load_cycles"}, cyc, n + 1);
    check_eq({tag, "_rom_addr_seq"}, bad, 0);
    check_eq({tag, "_rom_en_after"}, c_en, 1);
    check_eq({tag, "_no_irb_write"}, wr_cnt, 0);
  endtask

  task automatic exec_cmd(input logic [3:0] c, input string tag);
    cmd = c;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq({tag, "_busy_on"}, c_busy, 1);
    @(negedge clk);
    check_eq({tag, "_busy_off"}, c_busy, 0);
  endtask

  task automatic do_write(input int n, input string tag, input logic inject);
    int cyc;
    wr_cnt = 0;
    done_cnt = 0;
    seq_err = 1'b0;
    cmd = 4'd0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 0;
    while (done_cnt == 0 && cyc < 400) begin
      if (inject && cyc == 10) begin
        cmd = 4'd4;
        cmd_valid = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    cmd_valid = 1'b0;
    cmd = 4'd0;
    check_eq({tag, "_writes"}, wr_cnt, n);
    check_eq({tag, "_addr_seq"}, seq_err, 0);
    check_eq({tag, "_done_once"}, done_cnt, 1);
    check_eq({tag, "_done_busy"}, done_busy, 0);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, {c_done, c_rw}, 2'b01);
  endtask

  initial begin
    logic bad;
    int   cyc;
    for (int k = 0; k < 64; k++)  rom8[k]  = 8'(k);
    for (int k = 0; k < 128; k++) rom16[k] = 8'(k);
    @(negedge clk);

    // Identity load and write-out; a right command is pulsed mid-write and must be dropped.
    do_load(64, "load8");
    do_write(64, "wr_ident", 1'b1);
    bad = 1'b0;
    for (int k = 0; k < 64; k++) if (wr_mem[k] !== 8'(k)) bad = 1'b1;
    check_eq("img_ident", bad, 0);

    // Five ups saturate at py=1; max over (3..4,0..1) = 12.
    for (int i = 0; i < 5; i++) exec_cmd(4'd1, "up");
    exec_cmd(4'd5, "max");
    do_write(64, "wr_max", 1'b0);
    check_eq("max_a", wr_mem[3], 12);
    check_eq("max_b", wr_mem[4], 12);
    check_eq("max_c", wr_mem[11], 12);
    check_eq("max_d", wr_mem[12], 12);
    check_eq("max_keep", {wr_mem[2], wr_mem[5], wr_mem[13], wr_mem[20]}, {8'd2, 8'd5, 8'd13, 8'd20});

    // Average of 10,20,30,41 = floor(101/4) = 25; no-op first.
    rom8[27] = 8'd10; rom8[28] = 8'd20; rom8[35] = 8'd30; rom8[36] = 8'd41;
    do_load(64, "load_avg");
    exec_cmd(4'd12, "nop");
    exec_cmd(4'd7, "avg");
    do_write(64, "wr_avg", 1'b0);
    check_eq("avg_win", {wr_mem[27], wr_mem[28], wr_mem[35], wr_mem[36]}, {8'd25, 8'd25, 8'd25, 8'd25});
    check_eq("avg_keep", {wr_mem[26], wr_mem[37]}, {8'd26, 8'd37});

    // Window [1 2; 3 4] transforms.
    rom8[27] = 8'd1; rom8[28] = 8'd2; rom8[35] = 8'd3; rom8[36] = 8'd4;
    do_load(64, "load_rot");
    exec_cmd(4'd9, "rot_cw");
    do_write(64, "wr_cw", 1'b0);
    check_eq("rot_cw_win", {wr_mem[27], wr_mem[28], wr_mem[35], wr_mem[36]}, {8'd3, 8'd1, 8'd4, 8'd2});

    do_load(64, "load_mx");
    exec_cmd(4'd10, "mirror_x");
    do_write(64, "wr_mx", 1'b0);
    check_eq("mirror_x_win", {wr_mem[27], wr_mem[28], wr_mem[35], wr_mem[36]}, {8'd3, 8'd4, 8'd1, 8'd2});

    // CCW -> [2 4; 1 3], then mirror Y -> [4 2; 3 1].
    do_load(64, "load_ccw");
    exec_cmd(4'd8, "rot_ccw");
    exec_cmd(4'd11, "mirror_y");
    do_write(64, "wr_ccw", 1'b0);
    check_eq("ccw_my_win", {wr_mem[27], wr_mem[28], wr_mem[35], wr_mem[36]}, {8'd4, 8'd2, 8'd3, 8'd1});

    // Left and down saturate at (1,7): min over (0..1,6..7) = 48.
    do_load(64, "load_min");
    for (int i = 0; i < 4; i++) exec_cmd(4'd3, "left");
    for (int i = 0; i < 4; i++) exec_cmd(4'd2, "down");
    exec_cmd(4'd6, "min");
    do_write(64, "wr_min", 1'b0);
    check_eq("min_win", {wr_mem[48], wr_mem[49], wr_mem[56], wr_mem[57]}, {8'd48, 8'd48, 8'd48, 8'd48});
    check_eq("min_keep", {wr_mem[50], wr_mem[40], wr_mem[58]}, {8'd50, 8'd40, 8'd58});

    // 16x8 instance: reset during write cycle 20 aborts at once.
    rst8 = 1'b0;
    sel = 1'b1;
    @(negedge clk);
    do_load(128, "load16");
    wr_cnt = 0;
    cmd = 4'd0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 0;
    while (wr_cnt < 20 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("abort_reach", wr_cnt, 20);
    rst16 = 1'b0;
    #1;
    check_eq("abort_busy", busy16, 1);
    check_eq("abort_ctl", {done16, en16, rw16}, 3'b011);
    check_eq("abort_addr", {ra16, wa16, d16}, 0);
    @(negedge clk);
    do_load(128, "reload16");
    do_write(128, "wr16", 1'b0);
    bad = 1'b0;
    for (int k = 0; k < 128; k++) if (wr_mem[k] !== 8'(k)) bad = 1'b1;
    check_eq("img16_ident", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
